// File: rtl/helppll_dacloop_if.sv
// Frequency-difference stream from the helper-PLL frequency detector into the DAC loop.
// The detector drives the master side; the loop filter consumes the slave side.
interface helppll_dacloop_if #(
  parameter int DWIDTH = 32
);
  logic signed [DWIDTH-1:0] freqdiff;
  logic                     stb_freqdiff;

  modport master (
    output freqdiff,
    output stb_freqdiff
  );

  modport slave (
    input freqdiff,
    input stb_freqdiff
  );
endinterface

// File: rtl/helppll_dacloop.sv
// Helper-PLL loop closure: saturating PI filter feeding a 3-wire serial tuning DAC.
// Define HELPPLL_LOCKDET_EN to build the lock detector; otherwise locked is tied low.
module helppll_dacloop #(
  parameter int DWIDTH   = 32,
  parameter int DACW     = 16,
  parameter int KP_SHIFT = 4,
  parameter int KI_SHIFT = 10,
  parameter int SCLK_DIV = 4,
  parameter int LOCK_TOL = 8,
  parameter int LOCK_CNT = 16
) (
  input  logic                     clk,
  input  logic                     aresetn,
  helppll_dacloop_if.slave         fd_if,
  input  logic                     enable,
  input  logic [DACW-1:0]          dac_center,
  output logic [DACW-1:0]          dac_code,
  output logic                     dac_cs_n,
  output logic                     dac_sclk,
  output logic                     dac_sdi,
  output logic                     dac_busy,
  output logic                     locked,
  output logic signed [DWIDTH+7:0] dbinteg
);

  localparam int IW   = DWIDTH + 8;
  localparam int SW   = DWIDTH + 9;
  localparam int CDW  = SW + 1;
  localparam int DIVW = $clog2(SCLK_DIV + 1);
  localparam int BITW = $clog2(DACW + 1);

  localparam logic signed [IW:0]    INTEG_MAX = {2'b00, {(IW-1){1'b1}}};
  localparam logic signed [IW:0]    INTEG_MIN = {2'b11, {(IW-2){1'b0}}, 1'b1};
  localparam logic signed [CDW-1:0] CODE_MAX  = {{(CDW-DACW){1'b0}}, {DACW{1'b1}}};

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_SHIFT,
    WR_GAP
  } wr_state_e;

  logic signed [DWIDTH-1:0] fd_q, fd_d;
  logic signed [IW-1:0]     integ_q, integ_d;
  logic signed [SW-1:0]     sum_q, sum_d;
  logic [DACW-1:0]          dac_code_q, dac_code_d;
  logic                     v1_q, v1_d, v2_q, v2_d, upd_q, upd_d;

  logic signed [IW:0]       integ_ext;
  logic signed [DWIDTH-1:0] p_term;
  logic signed [IW-1:0]     i_term;
  logic signed [CDW-1:0]    code_ext;

  // Three strobe-qualified stages: integrate, combine P+I, then map around the centre code.
  always_comb begin
    fd_d       = fd_q;
    integ_d    = integ_q;
    sum_d      = sum_q;
    dac_code_d = dac_code_q;
    v1_d       = fd_if.stb_freqdiff;
    v2_d       = v1_q;
    upd_d      = v2_q;

    integ_ext = $signed({integ_q[IW-1], integ_q})
              + $signed({{(IW+1-DWIDTH){fd_if.freqdiff[DWIDTH-1]}}, fd_if.freqdiff});
    p_term    = fd_q >>> KP_SHIFT;
    i_term    = integ_q >>> KI_SHIFT;
    code_ext  = $signed({{(CDW-DACW){1'b0}}, dac_center}) - $signed({sum_q[SW-1], sum_q});

    if (fd_if.stb_freqdiff) begin
      fd_d = fd_if.freqdiff;
      if (integ_ext > INTEG_MAX) begin
        integ_d = INTEG_MAX[IW-1:0];
      end else if (integ_ext < INTEG_MIN) begin
        integ_d = INTEG_MIN[IW-1:0];
      end else begin
        integ_d = integ_ext[IW-1:0];
      end
    end
    if (!enable) begin
      integ_d = '0;
    end

    if (v1_q) begin
      if (enable) begin
        sum_d = $signed({{(SW-DWIDTH){p_term[DWIDTH-1]}}, p_term})
              + $signed({{(SW-IW){i_term[IW-1]}}, i_term});
      end else begin
        sum_d = '0;
      end
    end

    // Positive freqdiff means the helper runs fast, so the code moves down.
    if (v2_q) begin
      if (code_ext[CDW-1]) begin
        dac_code_d = '0;
      end else if (code_ext > CODE_MAX) begin
        dac_code_d = '1;
      end else begin
        dac_code_d = code_ext[DACW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      fd_q       <= '0;
      integ_q    <= '0;
      sum_q      <= '0;
      dac_code_q <= {1'b1, {(DACW-1){1'b0}}};
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      upd_q      <= 1'b0;
    end else begin
      fd_q       <= fd_d;
      integ_q    <= integ_d;
      sum_q      <= sum_d;
      dac_code_q <= dac_code_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      upd_q      <= upd_d;
    end
  end

  wr_state_e       state_q;
  logic [DACW-1:0] shreg_q;
  logic [DIVW-1:0] div_q;
  logic [BITW-1:0] bit_q;
  logic            cs_n_q, sclk_q, busy_q, pend_q;

  // Serial writer; pending starts set so the midscale code is written after every reset.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= WR_IDLE;
      shreg_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= 1'b1;
    end else begin
      case (state_q)
        WR_IDLE: begin
          if (upd_q || pend_q) begin
            shreg_q <= dac_code_q;
            cs_n_q  <= 1'b0;
            sclk_q  <= 1'b0;
            busy_q  <= 1'b1;
            pend_q  <= 1'b0;
            div_q   <= '0;
            bit_q   <= '0;
            state_q <= WR_SHIFT;
          end
        end
        WR_SHIFT: begin
          if (upd_q) begin
            pend_q <= 1'b1;
          end
          if (div_q == DIVW'(SCLK_DIV - 1)) begin
            div_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
              if (bit_q == BITW'(DACW - 1)) begin
                cs_n_q  <= 1'b1;
                shreg_q <= '0;
                state_q <= WR_GAP;
              end else begin
                bit_q   <= bit_q + BITW'(1);
                shreg_q <= {shreg_q[DACW-2:0], 1'b0};
              end
            end
          end else begin
            div_q <= div_q + DIVW'(1);
          end
        end
        WR_GAP: begin
          if (upd_q) begin
            pend_q <= 1'b1;
          end
          if (div_q == DIVW'(SCLK_DIV - 1)) begin
            div_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= WR_IDLE;
          end else begin
            div_q <= div_q + DIVW'(1);
          end
        end
        default: begin
          state_q <= WR_IDLE;
        end
      endcase
    end
  end

`ifdef HELPPLL_LOCKDET_EN
  localparam int CW = $clog2(LOCK_CNT + 1);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic            locked_q, locked_d;
  logic [DWIDTH:0] fd_abs;

  // Magnitude is taken one bit wider so the most negative word cannot overflow.
  always_comb begin
    cnt_d    = cnt_q;
    locked_d = locked_q;
    fd_abs   = fd_if.freqdiff[DWIDTH-1]
             ? (~{1'b1, fd_if.freqdiff} + (DWIDTH+1)'(1))
             : {1'b0, fd_if.freqdiff};
    if (!enable) begin
      cnt_d    = '0;
      locked_d = 1'b0;
    end else if (fd_if.stb_freqdiff) begin
      if (fd_abs <= (DWIDTH+1)'(LOCK_TOL)) begin
        if (cnt_q < CW'(LOCK_CNT)) begin
          cnt_d = cnt_q + CW'(1);
        end
        if (cnt_q >= CW'(LOCK_CNT - 1)) begin
          locked_d = 1'b1;
        end
      end else begin
        cnt_d    = '0;
        locked_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

  assign dac_code = dac_code_q;
  assign dac_cs_n = cs_n_q;
  assign dac_sclk = sclk_q;
  assign dac_sdi  = shreg_q[DACW-1];
  assign dac_busy = busy_q;
  assign dbinteg  = integ_q;

endmodule
